// File: rtl/mem_port_request_queue_if.sv
// ---------------------------------------------------------------------------
// mem_port_request_queue_if
//   Bundles every signal of the request queue except clock and reset:
//   - client request side: req_valid / req_ready / req_write / req_addr / req_wdata
//   - client response side: rsp_valid / rsp_rdata
//   - controller port side: mc_wr_addr / mc_wr_data / mc_wr_enable / mc_wr_grant,
//                           mc_rd_addr / mc_rd_grant / mc_rd_data
//   - status: count (occupied entries), retry_err (sticky starvation flag)
//   The slave modport is the queue's view; master is the surrounding
//   environment (client plus controller port).
// ---------------------------------------------------------------------------
interface mem_port_request_queue_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic [ADDR_W-1:0] mc_wr_addr;
   logic [DATA_W-1:0] mc_wr_data;
   logic              mc_wr_enable;
   logic              mc_wr_grant;
   logic [ADDR_W-1:0] mc_rd_addr;
   logic              mc_rd_grant;
   logic [DATA_W-1:0] mc_rd_data;
   logic [CNT_W-1:0]  count;
   logic              retry_err;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      input  mc_wr_grant, mc_rd_grant, mc_rd_data,
      output req_ready, rsp_valid, rsp_rdata,
      output mc_wr_addr, mc_wr_data, mc_wr_enable, mc_rd_addr,
      output count, retry_err
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      output mc_wr_grant, mc_rd_grant, mc_rd_data,
      input  req_ready, rsp_valid, rsp_rdata,
      input  mc_wr_addr, mc_wr_data, mc_wr_enable, mc_rd_addr,
      input  count, retry_err
   );
endinterface

// File: rtl/mem_port_request_queue.sv
// ---------------------------------------------------------------------------
// mem_port_request_queue
//   Per-client front-end for one read/write port pair of the block memory
//   controller. Buffers mixed read/write requests in an in-order FIFO, keeps
//   presenting the head request until the controller grants it, returns read
//   data in request order two cycles after the grant, and raises a sticky
//   flag when the head has waited RETRY_LIMIT consecutive cycles.
//   Ports:
//     clk   - rising-edge clock
//     reset - asynchronous, active-low reset
//     bus   - mem_port_request_queue_if.slave (client, controller, status)
// ---------------------------------------------------------------------------
module mem_port_request_queue #(
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 4,
   parameter int RETRY_LIMIT = 15
) (
   input  logic                     clk,
   input  logic                     reset,
   mem_port_request_queue_if.slave  bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int RTY_W = $clog2(RETRY_LIMIT + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(RETRY_LIMIT);

   logic              r_fifoWr   [DEPTH];
   logic [ADDR_W-1:0] r_fifoAddr [DEPTH];
   logic [DATA_W-1:0] r_fifoData [DEPTH];
   logic [PTR_W-1:0]  r_wrPtr;
   logic [PTR_W-1:0]  r_rdPtr;
   logic [CNT_W-1:0]  r_count;
   logic [ADDR_W-1:0] r_heldWrAddr;
   logic [DATA_W-1:0] r_heldWrData;
   logic [ADDR_W-1:0] r_heldRdAddr;
   logic              r_rdPending;
   logic              r_rspValid;
   logic [DATA_W-1:0] r_rspData;
   logic [RTY_W-1:0]  r_retryCnt;
   logic              r_retryErr;

   logic              w_empty;
   logic              w_full;
   logic              w_push;
   logic              w_headWr;
   logic [ADDR_W-1:0] w_headAddr;
   logic [DATA_W-1:0] w_headData;
   logic              w_wrIssue;
   logic              w_rdIssue;
   logic              w_rdGrant;
   logic              w_pop;
   logic [RTY_W-1:0]  w_retryNext;

   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == FULL_CNT);
   assign w_push     = bus.req_valid && !w_full;
   assign w_headWr   = r_fifoWr[r_rdPtr];
   assign w_headAddr = r_fifoAddr[r_rdPtr];
   assign w_headData = r_fifoData[r_rdPtr];
   assign w_wrIssue  = !w_empty && w_headWr;
   assign w_rdIssue  = !w_empty && !w_headWr;
   // Each grant only counts for the kind of request currently at the head
   assign w_rdGrant  = w_rdIssue && bus.mc_rd_grant;
   assign w_pop      = (w_wrIssue && bus.mc_wr_grant) || w_rdGrant;

   // Ready ignores a same-cycle pop so it never depends on the grant inputs
   assign bus.req_ready    = !w_full;
   assign bus.count        = r_count;
   assign bus.mc_wr_enable = w_wrIssue;
   // Buses not in use fall back to the last value they carried
   assign bus.mc_wr_addr   = w_wrIssue ? w_headAddr : r_heldWrAddr;
   assign bus.mc_wr_data   = w_wrIssue ? w_headData : r_heldWrData;
   assign bus.mc_rd_addr   = w_rdIssue ? w_headAddr : r_heldRdAddr;
   assign bus.rsp_valid    = r_rspValid;
   assign bus.rsp_rdata    = r_rspData;
   assign bus.retry_err    = r_retryErr;

   // Starvation counter: counts ungranted cycles of a valid head, cleared by
   // any pop, saturating so the sticky flag can be derived from it
   always_comb begin
      w_retryNext = r_retryCnt;
      if (w_pop) begin
         w_retryNext = '0;
      end else if (!w_empty && (r_retryCnt != RTY_MAX)) begin
         w_retryNext = r_retryCnt + RTY_W'(1);
      end
   end

   // FIFO storage, pointers and occupancy; pointers wrap naturally because
   // DEPTH is a power of two
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_fifoWr[i]   <= 1'b0;
            r_fifoAddr[i] <= '0;
            r_fifoData[i] <= '0;
         end
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_fifoWr[r_wrPtr]   <= bus.req_write;
            r_fifoAddr[r_wrPtr] <= bus.req_addr;
            r_fifoData[r_wrPtr] <= bus.req_wdata;
            r_wrPtr             <= r_wrPtr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   // Remember what each controller bus last carried so it holds when idle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_heldWrAddr <= '0;
         r_heldWrData <= '0;
         r_heldRdAddr <= '0;
      end else begin
         if (w_wrIssue) begin
            r_heldWrAddr <= w_headAddr;
            r_heldWrData <= w_headData;
         end
         if (w_rdIssue) begin
            r_heldRdAddr <= w_headAddr;
         end
      end
   end

   // Read response pipeline: grant in G, controller data arrives in G+1 and
   // is captured at its end, response pulses during G+2
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rdPending <= 1'b0;
         r_rspValid  <= 1'b0;
         r_rspData   <= '0;
      end else begin
         r_rdPending <= w_rdGrant;
         r_rspValid  <= r_rdPending;
         if (r_rdPending) begin
            r_rspData <= bus.mc_rd_data;
         end
      end
   end

   // Retry counter and sticky starvation flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_retryCnt <= '0;
         r_retryErr <= 1'b0;
      end else begin
         r_retryCnt <= w_retryNext;
         if (w_retryNext == RTY_MAX) begin
            r_retryErr <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_mem_port_request_queue.sv
// ---------------------------------------------------------------------------
// tb_mem_port_request_queue
//   Drives client requests and emulates the controller port. The model keeps
//   the expected queue contents as a plain queue of requests, a controller
//   memory array, and a reference memory updated at request time so read
//   responses are predicted purely from request order.
// ---------------------------------------------------------------------------
module tb_mem_port_request_queue;
   localparam int DEPTH = 4;
   localparam int LIMIT = 15;

   typedef struct packed {
      logic        wr;
      logic [11:0] addr;
      logic [31:0] data;
   } req_t;

   typedef enum {GM_ALWAYS, GM_NONE, GM_RANDOM} grant_mode_e;

   logic clk;
   logic reset;

   mem_port_request_queue_if #(.ADDR_W(12), .DATA_W(32), .DEPTH(DEPTH)) bus ();

   mem_port_request_queue #(
      .ADDR_W(12), .DATA_W(32), .DEPTH(DEPTH), .RETRY_LIMIT(LIMIT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int          checks   = 0;
   int          failures = 0;

   req_t        modelQ[$];
   logic [31:0] expRsp[$];
   logic [31:0] ctrlMem [4096];
   logic [31:0] refMem  [4096];

   grant_mode_e grantMode  = GM_ALWAYS;
   int          holdCycles = 0;
   logic        grantOnce  = 1'b0;
   logic        acceptFlag = 1'b0;

   int          retryCnt;
   logic        retryErrExp;
   logic [11:0] lastWrAddr;
   logic [31:0] lastWrData;
   logic [11:0] lastRdAddr;
   logic [31:0] lastRsp;
   logic        gh1;
   logic        gh2;
   logic [11:0] pendRdAddr;

   logic        headValid;
   req_t        head;
   logic        wrG;
   logic        rdG;
   logic        doPop;
   logic        thisRd;
   logic        accept;
   req_t        newReq;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Controller emulation and reference model, evaluated mid-cycle: first
   // compare the DUT against the model state, then choose this cycle's
   // grants and advance the model to its post-edge state.
   always @(negedge clk) begin
      if (!reset) begin
         modelQ.delete();
         expRsp.delete();
         refMem      = ctrlMem;
         retryCnt    = 0;
         retryErrExp = 1'b0;
         lastWrAddr  = '0;
         lastWrData  = '0;
         lastRdAddr  = '0;
         lastRsp     = '0;
         gh1         = 1'b0;
         gh2         = 1'b0;
         acceptFlag  = 1'b0;
         bus.mc_wr_grant = 1'b0;
         bus.mc_rd_grant = 1'b0;
         bus.mc_rd_data  = $urandom();
         checkOutput("reset count", 64'(bus.count), 64'(0));
         checkOutput("reset req_ready", 64'(bus.req_ready), 64'(1));
         checkOutput("reset rsp_valid", 64'(bus.rsp_valid), 64'(0));
         checkOutput("reset rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
         checkOutput("reset wr_enable", 64'(bus.mc_wr_enable), 64'(0));
         checkOutput("reset wr_addr", 64'(bus.mc_wr_addr), 64'(0));
         checkOutput("reset wr_data", 64'(bus.mc_wr_data), 64'(0));
         checkOutput("reset rd_addr", 64'(bus.mc_rd_addr), 64'(0));
         checkOutput("reset retry_err", 64'(bus.retry_err), 64'(0));
      end else begin
         headValid = (modelQ.size() > 0);
         head      = headValid ? modelQ[0] : '0;

         checkOutput("count", 64'(bus.count), 64'(modelQ.size()));
         checkOutput("req_ready", 64'(bus.req_ready), 64'(modelQ.size() != DEPTH));
         checkOutput("wr_enable", 64'(bus.mc_wr_enable), 64'(headValid && head.wr));
         checkOutput("wr_addr", 64'(bus.mc_wr_addr),
                     64'((headValid && head.wr) ? head.addr : lastWrAddr));
         checkOutput("wr_data", 64'(bus.mc_wr_data),
                     64'((headValid && head.wr) ? head.data : lastWrData));
         checkOutput("rd_addr", 64'(bus.mc_rd_addr),
                     64'((headValid && !head.wr) ? head.addr : lastRdAddr));
         checkOutput("retry_err", 64'(bus.retry_err), 64'(retryErrExp));
         checkOutput("rsp_valid", 64'(bus.rsp_valid), 64'(gh2));
         if (gh2) begin
            if (expRsp.size() == 0) begin
               checkOutput("rsp unexpected", 64'(bus.rsp_rdata), 64'(0));
            end else begin
               lastRsp = expRsp.pop_front();
               checkOutput("rsp_rdata", 64'(bus.rsp_rdata), 64'(lastRsp));
            end
         end else begin
            checkOutput("rsp_rdata hold", 64'(bus.rsp_rdata), 64'(lastRsp));
         end

         if (headValid && head.wr) begin
            lastWrAddr = head.addr;
            lastWrData = head.data;
         end
         if (headValid && !head.wr) begin
            lastRdAddr = head.addr;
         end

         // Data for a read granted in the previous cycle, garbage otherwise
         bus.mc_rd_data = gh1 ? ctrlMem[pendRdAddr] : $urandom();

         case (grantMode)
            GM_ALWAYS: begin wrG = headValid && head.wr; rdG = 1'b1; end
            GM_NONE:   begin wrG = 1'b0; rdG = 1'b0; end
            default:   begin wrG = 1'($urandom_range(0, 1)); rdG = 1'($urandom_range(0, 1)); end
         endcase
         if (holdCycles > 0 && headValid) begin
            wrG = 1'b0;
            rdG = 1'b0;
            holdCycles--;
         end
         if (grantOnce) begin
            wrG = 1'b1;
            rdG = 1'b1;
            grantOnce = 1'b0;
         end
         bus.mc_wr_grant = wrG;
         bus.mc_rd_grant = rdG;

         doPop  = headValid && (head.wr ? wrG : rdG);
         thisRd = headValid && !head.wr && rdG;
         if (doPop && head.wr) ctrlMem[head.addr] = head.data;
         if (thisRd) pendRdAddr = head.addr;

         if (headValid) begin
            if (doPop) retryCnt = 0;
            else if (retryCnt < LIMIT) retryCnt++;
            if (retryCnt == LIMIT) retryErrExp = 1'b1;
         end

         accept     = bus.req_valid && (modelQ.size() != DEPTH);
         acceptFlag = accept;
         if (doPop) void'(modelQ.pop_front());
         if (accept) begin
            newReq.wr   = bus.req_write;
            newReq.addr = bus.req_addr;
            newReq.data = bus.req_wdata;
            modelQ.push_back(newReq);
         end
         gh2 = gh1;
         gh1 = thisRd;
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Offer one request for up to maxWait edges; expected read data is taken
   // from the reference memory as it stands after all earlier requests
   task automatic applyStimulus(input logic wr, input logic [11:0] addr,
                                input logic [31:0] data, input int maxWait,
                                output logic accepted);
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = addr;
      bus.req_wdata = data;
      accepted = 1'b0;
      for (int i = 0; i < maxWait && !accepted; i++) begin
         @(posedge clk);
         #1;
         if (acceptFlag) accepted = 1'b1;
      end
      bus.req_valid = 1'b0;
      bus.req_wdata = $urandom();
      if (accepted) begin
         if (wr) refMem[addr] = data;
         else    expRsp.push_back(refMem[addr]);
      end
   endtask

   task automatic waitDrain(input int maxCycles);
      logic drained;
      drained = 1'b0;
      for (int i = 0; i < maxCycles && !drained; i++) begin
         if (modelQ.size() == 0 && !gh1 && !gh2) drained = 1'b1;
         else idle(1);
      end
      checkOutput("drain", 64'(drained), 64'(1));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic acc;
      for (int i = 0; i < 4096; i++) ctrlMem[i] = $urandom();
      ctrlMem[50] = 32'hBBBB_BBBB;
      refMem = ctrlMem;
      reset = 1'b0;
      bus.req_valid   = 1'b0;
      bus.req_write   = 1'b0;
      bus.req_addr    = '0;
      bus.req_wdata   = '0;
      bus.mc_wr_grant = 1'b0;
      bus.mc_rd_grant = 1'b0;
      bus.mc_rd_data  = '0;
      idle(3);
      reset = 1'b1;
      idle(1);

      $display("[TB] plain write and read");
      grantMode = GM_ALWAYS;
      applyStimulus(1'b1, 12'd257, 32'hAAAA_AAAA, 5, acc);
      checkOutput("write accept", 64'(acc), 64'(1));
      applyStimulus(1'b0, 12'd50, 32'h0, 5, acc);
      checkOutput("read accept", 64'(acc), 64'(1));
      waitDrain(20);

      $display("[TB] write held off by conflicts");
      holdCycles = 3;
      applyStimulus(1'b1, 12'd300, 32'h1234_5678, 5, acc);
      waitDrain(20);

      $display("[TB] fill to full then drain with wrap");
      grantMode = GM_NONE;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 12'(100 + i), 32'(32'hC000_0000 + i), 3, acc);
         checkOutput("fill accept", 64'(acc), 64'(1));
      end
      applyStimulus(1'b1, 12'd104, 32'hC000_0004, 3, acc);
      checkOutput("full refuse", 64'(acc), 64'(0));
      checkOutput("full count", 64'(bus.count), 64'(4));
      grantMode = GM_ALWAYS;
      applyStimulus(1'b1, 12'd104, 32'hC000_0004, 5, acc);
      checkOutput("fifth accept", 64'(acc), 64'(1));
      waitDrain(20);

      $display("[TB] starvation");
      grantMode = GM_NONE;
      applyStimulus(1'b1, 12'd77, 32'hDEAD_0077, 3, acc);
      idle(20);
      grantMode = GM_ALWAYS;
      waitDrain(20);
      idle(3);

      $display("[TB] reset mid-operation");
      grantMode = GM_NONE;
      applyStimulus(1'b0, 12'd50, 32'h0, 3, acc);
      applyStimulus(1'b1, 12'd60, 32'h6060_6060, 3, acc);
      applyStimulus(1'b1, 12'd61, 32'h6161_6161, 3, acc);
      grantOnce = 1'b1;
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("async reset count", 64'(bus.count), 64'(0));
      checkOutput("async reset wr_enable", 64'(bus.mc_wr_enable), 64'(0));
      idle(2);
      reset = 1'b1;
      grantMode = GM_ALWAYS;
      idle(6);

      $display("[TB] randomized traffic");
      grantMode = GM_RANDOM;
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 3) == 0) idle(1);
         applyStimulus(1'($urandom_range(0, 1)), 12'($urandom_range(0, 7)),
                       $urandom(), 50, acc);
         checkOutput("random accept", 64'(acc), 64'(1));
      end
      grantMode = GM_ALWAYS;
      waitDrain(50);
      checkOutput("leftover responses", 64'(expRsp.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_port_request_queue.md
Name: mem_port_request_queue

Overview:
- Per-client request front-end placed directly upstream of one read/write port pair of block_memory_controller.
- Accepts mixed read/write requests from one client over a valid/ready handshake and buffers them in an in-order FIFO.
- Drives the controller port with the head request and re-issues it every cycle until the controller grants it, which covers block conflicts with other ports.
- Returns read data in request order and flags starvation.

Parameters:
ADDR_W, 12, address width; matches the controller's 4096-word space.
DATA_W, 32, data width.
DEPTH, 4, FIFO entries; power of two, minimum 2.
RETRY_LIMIT, 15, consecutive ungranted issue cycles after which retry_err sets.

Ports:
clk  in  1  clock; all logic is rising-edge.
reset  in  1  asynchronous, active-low reset.
req_valid  in  1  client request valid.
req_ready  out  1  queue can accept a request this cycle.
req_write  in  1  1 = write, 0 = read.
req_addr  in  ADDR_W  request address.
req_wdata  in  DATA_W  write data; ignored for reads.
rsp_valid  out  1  one-cycle pulse when rsp_rdata holds read data.
rsp_rdata  out  DATA_W  read response data.
mc_wr_addr  out  ADDR_W  to controller wr_addrN.
mc_wr_data  out  DATA_W  to controller wr_dataN.
mc_wr_enable  out  1  to controller wr_enableN.
mc_wr_grant  in  1  from controller wr_enable_outN; the write is committed in this cycle.
mc_rd_addr  out  ADDR_W  to controller rd_addrN.
mc_rd_grant  in  1  from controller rd_enableN; the read is granted in this cycle.
mc_rd_data  in  DATA_W  from controller rd_dataN; valid the cycle after the grant.
count  out  log2(DEPTH)+1  number of occupied FIFO entries.
retry_err  out  1  sticky starvation flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO is emptied, pointers and count go to 0, retry counter goes to 0.
  - Response pipeline is flushed. Any read granted before reset produces no rsp_valid.
  - Outputs: req_ready=1, rsp_valid=0, rsp_rdata=0, mc_wr_enable=0, mc_wr_addr=0, mc_wr_data=0, mc_rd_addr=0, count=0, retry_err=0.
- Accept:
  - A push occurs when req_valid && req_ready at a rising edge.
  - req_ready = (count != DEPTH). It does not account for a same-cycle pop, so a full queue refuses even if the head pops in that cycle.
  - A push and a pop in the same cycle leave count unchanged.
- Issue: the head entry is driven combinationally from its registered FIFO storage.
  - Head is a write: mc_wr_enable=1, with mc_wr_addr and mc_wr_data set to the head entry.
  - Head is a read: mc_rd_addr = head address and mc_wr_enable=0.
  - Queue empty: mc_wr_enable=0; mc_rd_addr and the write buses hold their last values.
- Grant and pop:
  - The head pops at the edge ending a cycle in which it was granted: mc_wr_grant=1 for a write head, or mc_rd_grant=1 for a read head.
  - mc_rd_grant is ignored when the head is not a read. mc_wr_grant is ignored when mc_wr_enable=0.
  - The next entry is issued in the following cycle, so sustained throughput is 1 request per cycle.
- Read response:
  - Read granted in cycle G: mc_rd_data is captured at the edge ending cycle G+1.
  - rsp_valid=1 with that data during cycle G+2, for exactly one cycle.
  - rsp_rdata holds its value afterwards.
  - The response path has no backpressure. Responses are in request order, and writes produce no response.
- Retry counter:
  - Counts consecutive cycles with a valid head and no grant. It clears on any pop and saturates at RETRY_LIMIT.
  - When it reaches RETRY_LIMIT, retry_err is set at that edge and stays set until reset.
  - The head keeps retrying indefinitely; there is no drop and no reorder.
- Wrap-around: read and write pointers wrap modulo DEPTH. Full is count==DEPTH, empty is count==0.
- Hazards: in-order issue is the only ordering guarantee. A read queued after a write to the same address sees the new data, because the write pops before the read issues.

Test Plan:
1. Reset, then push write (addr 257, data AAAA_AAAA) with mc_wr_grant tied to mc_wr_enable.
   - Required: mc_wr_enable=1, mc_wr_addr=257 in the cycle after the push; count returns to 0 the cycle after that.
2. Push read addr 50; mc_rd_grant=1 in cycle G; model drives mc_rd_data=BBBB_BBBB in G+1.
   - Required: rsp_valid=1, rsp_rdata=BBBB_BBBB in G+2 only.
3. Hold mc_wr_grant=0 for 3 cycles then 1, emulating a same-block conflict with another port.
   - Required: mc_wr_enable, addr and data stay stable for 4 cycles; pop occurs on the 4th cycle; retry_err stays 0.
4. Push 5 writes back-to-back with no grants, DEPTH=4.
   - Required: req_ready=0 after the 4th push and the 5th is not accepted; count=4.
   - Then grant every cycle: mc_wr_addr sequence matches push order, one per cycle, with pointer wrap exercised.
5. Withhold all grants for 15 cycles.
   - Required: retry_err rises at the 15th ungranted edge and stays 1 after later grants; it is cleared only by reset=0.
6. Assert reset=0 mid-operation: 2 entries queued and a read granted one cycle earlier.
   - Required: count=0 and mc_wr_enable=0 immediately; no rsp_valid pulse afterwards.
